// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// valid/ready memory channel and presents {pc, inst} to decode.
// Ports:
//   clk, rst (async, active-low)
//   imem_req_valid/addr/ready : fetch request channel
//   imem_rsp_valid/data       : fetch response (no back-pressure)
//   inst_valid/inst/pc/ready  : instruction channel toward decode
//   redirect_valid/pc         : PC redirect from execute
//   halt                      : ebreak, stop fetching until reset
module ysyx_22050854_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    logic [2:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        drop;
    logic [31:0] target;
    logic        unused_lo;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign unused_lo = ^{redirect_pc[1:0], RESET_PC[1:0]};

    // every output comes straight from registered state
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == HOLD);
    assign inst           = inst_q;
    assign pc             = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= BOOT_PC;
            inst_q   <= 32'h0;
            pc_q     <= BOOT_PC;
            drop     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else begin
                        if (redirect_valid) fetch_pc <= target;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (halt) begin
                        // an accepted request still owes us a response
                        if (imem_req_ready) drop <= 1'b1;
                        state <= HALTED;
                    end else if (imem_req_ready) begin
                        if (redirect_valid) begin
                            drop     <= 1'b1;
                            fetch_pc <= target;
                        end
                        state <= WAIT;
                    end else if (redirect_valid) begin
                        fetch_pc <= target;
                    end
                end
                WAIT: begin
                    if (halt) begin
                        drop  <= !imem_rsp_valid;
                        state <= HALTED;
                    end else if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                            if (redirect_valid) fetch_pc <= target;
                        end else begin
                            inst_q <= imem_rsp_data;
                            pc_q   <= fetch_pc;
                            state  <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop     <= 1'b1;
                        fetch_pc <= target;
                    end
                end
                HOLD: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (redirect_valid) begin
                        // held word is stale even if decode takes it now
                        fetch_pc <= target;
                        state    <= REQ;
                    end else if (inst_ready) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= REQ;
                    end
                end
                HALTED: begin
                    // swallow the response of a request abandoned by halt
                    if (imem_rsp_valid) drop <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
